// File: rtl/sps_match_scoreboard.sv
// Best-of match scoreboard for the stone-paper-scissors round evaluator.
// Counts round results during PLAY and declares a winner or a draw at the round cap.
module sps_match_scoreboard #(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 9,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_match,
  input  logic             res_valid,
  input  logic [1:0]       res_winner,
  output logic             res_ready,
  output logic [CNT_W-1:0] p1_score,
  output logic [CNT_W-1:0] p2_score,
  output logic [CNT_W-1:0] tie_count,
  output logic [CNT_W-1:0] round_count,
  output logic             invalid_seen,
  output logic [1:0]       match_state,
  output logic [1:0]       match_winner,
  output logic             match_done
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;

  localparam logic [1:0] RES_TIE = 2'b00;
  localparam logic [1:0] RES_P1  = 2'b01;
  localparam logic [1:0] RES_P2  = 2'b10;
  localparam logic [1:0] RES_BAD = 2'b11;

  localparam logic [CNT_W-1:0] TARGET_C = CNT_W'(WIN_TARGET);
  localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(MAX_ROUNDS);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_p1;
  logic [CNT_W-1:0] r_p2;
  logic [CNT_W-1:0] r_tie;
  logic [CNT_W-1:0] r_rounds;
  logic             r_invalid;
  logic [1:0]       r_winner;
  logic             r_done;

  logic             w_accept;
  logic             w_inc_p1;
  logic             w_inc_p2;
  logic             w_inc_tie;
  logic             w_inc_round;
  logic [CNT_W-1:0] w_p1_nxt;
  logic [CNT_W-1:0] w_p2_nxt;
  logic [CNT_W-1:0] w_tie_nxt;
  logic [CNT_W-1:0] w_rounds_nxt;
  logic             w_p1_wins;
  logic             w_p2_wins;
  logic             w_cap_hit;

  // new_match takes priority: a result arriving on the same edge is dropped.
  assign w_accept    = (r_state == ST_PLAY) && res_valid && !new_match;
  assign w_inc_p1    = w_accept && (res_winner == RES_P1);
  assign w_inc_p2    = w_accept && (res_winner == RES_P2);
  assign w_inc_tie   = w_accept && (res_winner == RES_TIE);
  assign w_inc_round = w_inc_p1 || w_inc_p2 || w_inc_tie;

  assign w_p1_nxt     = r_p1     + {{(CNT_W-1){1'b0}}, w_inc_p1};
  assign w_p2_nxt     = r_p2     + {{(CNT_W-1){1'b0}}, w_inc_p2};
  assign w_tie_nxt    = r_tie    + {{(CNT_W-1){1'b0}}, w_inc_tie};
  assign w_rounds_nxt = r_rounds + {{(CNT_W-1){1'b0}}, w_inc_round};

  // End check looks at post-update counts; a target hit on the cap round beats the draw.
  assign w_p1_wins = (w_p1_nxt == TARGET_C);
  assign w_p2_wins = (w_p2_nxt == TARGET_C);
  assign w_cap_hit = (w_rounds_nxt == CAP_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_p1      <= '0;
      r_p2      <= '0;
      r_tie     <= '0;
      r_rounds  <= '0;
      r_invalid <= 1'b0;
      r_winner  <= 2'b00;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (new_match) begin
        r_state   <= ST_PLAY;
        r_p1      <= '0;
        r_p2      <= '0;
        r_tie     <= '0;
        r_rounds  <= '0;
        r_invalid <= 1'b0;
        r_winner  <= 2'b00;
      end else if (w_accept) begin
        r_p1     <= w_p1_nxt;
        r_p2     <= w_p2_nxt;
        r_tie    <= w_tie_nxt;
        r_rounds <= w_rounds_nxt;
        if (res_winner == RES_BAD) begin
          r_invalid <= 1'b1;
        end
        if (w_p1_wins) begin
          r_state  <= ST_OVER;
          r_winner <= RES_P1;
          r_done   <= 1'b1;
        end else if (w_p2_wins) begin
          r_state  <= ST_OVER;
          r_winner <= RES_P2;
          r_done   <= 1'b1;
        end else if (w_cap_hit) begin
          r_state  <= ST_OVER;
          r_winner <= RES_TIE;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign res_ready    = (r_state == ST_PLAY);
  assign p1_score     = r_p1;
  assign p2_score     = r_p2;
  assign tie_count    = r_tie;
  assign round_count  = r_rounds;
  assign invalid_seen = r_invalid;
  assign match_state  = r_state;
  assign match_winner = r_winner;
  assign match_done   = r_done;

endmodule
